// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its word array.
// Optional feature macro used elsewhere: DMEM_RANGE_CHECK_EN.
package dmem_responder_pkg;

    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;  // wide enough to hold LAT_MAX - 1

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Request fields captured at acceptance and held for the whole transaction.
    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              err;
    } req_t;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous byte-enabled word RAM: one write port, one registered read port,
// whole array cleared by synchronous reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: clearing every word on reset forces this array into flops; a RAM macro cannot be reset this way.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (we) mem_q[addr] <= merge_bytes(mem_q[addr], wdata, be);
            // rdata only moves on a read, so it stays stable while a response waits.
            if (re) rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the CPU data-memory port: one request at a time, LAT-cycle latency.
// Define DMEM_RANGE_CHECK_EN to reject addresses beyond the array with rsp_err.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2   // legal range LAT_MIN..LAT_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [BE_W-1:0]   req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               req_q, req_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               zero_q, zero_d;
    logic               commit;
    logic               accept;
    logic               req_err;
    logic               arr_we, arr_re;
    logic [DATA_W-1:0]  arr_rdata;

`ifdef DMEM_RANGE_CHECK_EN
    logic unused_addr;
    assign unused_addr = ^req_addr[1:0];
    assign req_err     = |req_addr[31:ADDR_W+2];
`else
    logic unused_addr;
    assign unused_addr = ^{req_addr[1:0], req_addr[31:ADDR_W+2]};
    assign req_err     = 1'b0;
`endif

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign accept    = req_valid && req_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        idx_d   = idx_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.we    = req_we;
                    req_d.be    = req_be;
                    req_d.wdata = req_wdata;
                    req_d.err   = req_err;
                    idx_d       = req_addr[ADDR_W+1:2];
                    cnt_d       = CNT_W'(LAT - 1);
                    if (LAT == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // The edge that brings the counter to zero is the commit edge, so
                // rsp_valid is seen in the LAT-th cycle after acceptance.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // On the commit edge req_d/idx_d describe the transaction in flight, even
    // when it is committed on its own acceptance edge (LAT == 1).
    assign arr_we = commit &&  req_d.we && !req_d.err;
    assign arr_re = commit && !req_d.we && !req_d.err;
    assign zero_d = commit ? (req_d.we || req_d.err) : zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            zero_q  <= zero_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (idx_d),
        .be    (req_d.be),
        .wdata (req_d.wdata),
        .rdata (arr_rdata)
    );

    assign rsp_rdata = zero_q ? '0 : arr_rdata;
    assign rsp_err   = req_q.err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the CPU's load/store port: the slave end of the CPU data-memory interface.
- Accepts one request at a time over a valid/ready handshake and applies a configurable wait-state latency.
- Performs byte-enabled writes or word reads on an internal word array, then returns a response over a second valid/ready handshake.
- Used when the core moves from ideal zero-latency memory to a stalled, multi-cycle memory model.

Parameters:
- ADDR_W, 10, word-index width; the array holds DEPTH = 2**ADDR_W 32-bit words.
- LAT, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; word index = req_addr[ADDR_W+1:2].
- req_be  in  4  byte enables for stores; bit i enables byte lane [8i+7:8i].
- req_wdata  in  32  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  request rejected (see Optional Feature).

Behaviour:
- Reset, synchronous, active-high:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - All array words cleared to 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we/addr/be/wdata and load counter=LAT-1.
  - Go to RESP if LAT==1, else to WAIT.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter reaches 0, go to RESP on the next edge.
- Array commit on the WAIT->RESP (or IDLE->RESP) transition edge:
  - Store: write only the byte lanes with be[i]=1; other lanes are unchanged.
  - Load: rsp_rdata is registered from the array on the same edge.
- Latency: rsp_valid rises exactly LAT cycles after the acceptance edge.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that handshake, go to IDLE and drop rsp_valid.
  - The next request cannot be accepted on the handshake cycle itself; minimum issue interval is LAT+1 cycles.
- Store with be=0000: completes normally, array unchanged, rsp_rdata=0.
- req_addr[1:0] is ignored; accesses are always word-aligned.
- req_valid while not in IDLE: ignored (req_ready=0); the initiator must hold the request.
- Reset mid-operation (WAIT or RESP): aborts the transaction; an uncommitted store is dropped; state returns to IDLE.
- Load after store to the same word, back-to-back: returns the newly written data, since the store committed before its response.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - If req_addr[31:ADDR_W+2] != 0, the request still takes LAT cycles.
  - No array write occurs; the response has rsp_err=1 and rsp_rdata=0.
- Undefined:
  - Upper address bits are ignored, so the address wraps modulo DEPTH words.
  - rsp_err is tied to 0.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Data width constant 32 and byte-enable width 4.
  - LAT range limits.
- Natural sub-module: dmem_array, a synchronous byte-enabled word RAM with clear-on-reset, one write port and one registered read port.
- The FSM and latency counter stay in dmem_responder.

Test Plan:
- Reset, then load from addr 0x0000_0010 with LAT=2:
  - req_ready=1 after reset.
  - rsp_valid rises 2 cycles after acceptance with rsp_rdata=0x0000_0000, rsp_err=0.
- Store 0xDEADBEEF, be=1111, to 0x0000_0020; then load 0x20:
  - rdata=0xDEADBEEF.
- Store 0x11223344 with be=0101 onto 0xDEADBEEF at 0x20; load:
  - rdata=0xDE22BE44.
- Hold rsp_ready=0 for 5 cycles in RESP:
  - rsp_valid stays 1 with stable data; req_ready stays 0; a concurrent req_valid is not accepted.
  - Release rsp_ready: handshake completes, back to IDLE.
- Assert rst during WAIT of a store 0xCAFEF00D to 0x40:
  - IDLE next cycle; a subsequent load of 0x40 returns 0x00000000.
- Load from 0x0000_1000 (ADDR_W=10):
  - With DMEM_RANGE_CHECK_EN: rsp_err=1, rdata=0.
  - Without: aliases word 0, so rdata equals the contents of address 0x0.
